seq_decode: RTL and testbench
=============================

// Module: seq_decode
// PURPOSE
//  Receiving end of the sequencer's encoded output bus. Decodes the 4-bit enc code
//  into the 8-bit one-hot unenc vector and checks that the index advances by one
//  (mod 8) on every step. Reports lock, sequence errors and wrap.
//  Sits downstream of seq: seq.enc drives enc; step is tied high when both share clk.
// PARAMETERS
//  LOCK_COUNT  4  consecutive in-order active steps needed to assert locked (legal 2..255)
//  MISS_LIMIT  2  consecutive out-of-order steps while locked before lock drops (legal 1..255)
//  ERR_W       8  width of saturating error counter err_cnt
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  enc      in   4      encoded code: enc[3]=active, enc[2:0]=index 0..7
//  step     in   1      sample enable: enc is consumed on a rising clk edge with step=1
//  unenc    out  8      registered one-hot decode of the last sampled enc
//  locked   out  1      sequence checker is in LOCKED
//  err      out  1      1-cycle pulse: out-of-order step seen while locked
//  wrap     out  1      1-cycle pulse: in-order step with index 7 seen while locked
//  err_cnt  out  ERR_W  saturating count of err pulses since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): unenc=8'h00, locked=0, err=0, wrap=0, err_cnt=0,
//   state=HUNT, exp=0, good=0, miss=0. Outputs go low without waiting for a clk edge.
//  Decode, latency 1 clk: on a step edge, unenc <= enc[3] ? (8'h01 << enc[2:0]) : 8'h00.
//   When step=0, unenc holds its value.
//  Checker input: only active steps (step=1 and enc[3]=1) are seen by the FSM.
//   An inactive step (enc[3]=0) leaves exp, good, miss and state unchanged and raises no err.
//  match = (enc[2:0] == exp). exp is 3 bits and wraps 7 -> 0.
//  err and wrap are registered and default to 0. Each is high only during the cycle
//   after its qualifying edge.
//  FSM states HUNT, CHECK, LOCKED. Transitions happen on active steps only:
//   HUNT:   exp<=idx+1, good<=1, go to CHECK.
//   CHECK:  on match: exp++, good++. If good+1==LOCK_COUNT: go to LOCKED, locked<=1, miss<=0.
//           On mismatch: exp<=idx+1, good<=1, stay in CHECK. No err is raised in CHECK.
//   LOCKED: on match: exp++, miss<=0. If idx==7, wrap<=1.
//           On mismatch: err<=1, err_cnt<=err_cnt+1 saturating at all-ones, exp<=idx+1.
//             If miss+1==MISS_LIMIT: go to HUNT, locked<=0, miss<=0. Otherwise miss++.
//  locked updates on the same edge as the state change that causes it, so it is
//   visible 1 cycle after the decisive step.
//  A mismatching step that also drops lock still pulses err and counts it.
//  A mismatch with idx==7 never pulses wrap.
//  step=0: all state and outputs hold, except err and wrap, which return to 0.
//  Reset mid-operation: everything returns to reset values at once. The first active
//   step after release is treated as a HUNT step.
// TESTING
//  1 Reset, then step=1 every clk with enc=8,9,A,B,C,D,E,F,8 -> unenc=01,02,04,..80,01,
//    each 1 clk after its step; locked rises 1 clk after 4th step; wrap pulses after F.
//  2 Locked, enc idx sequence 0,1,2,3,5,6 -> single err pulse after 5, err_cnt=1,
//    locked stays 1; then 0,3 (two mismatches) -> err_cnt=3, locked=0 after 2nd.
//  3 Locked at exp=2, apply enc=4'h0 for 3 steps then enc=A -> unenc=00 during idle,
//    no err, locked stays 1, no wrap.
//  4 ERR_W=2, MISS_LIMIT=255, locked, apply 6 mismatching steps -> err_cnt 1,2,3,3,3,3;
//    err pulses 6 times; locked stays 1.
//  5 Locked mid-stream, drop rst_n between clk edges -> unenc, locked, err_cnt read 0
//    before the next edge; after release, LOCK_COUNT in-order steps relock.
//  6 step=0 for 5 clks with enc changing randomly -> unenc, locked, err_cnt unchanged,
//    err/wrap 0.

Source files
------------

// File: rtl/seq_decode.sv
// Decodes the sequencer's 4-bit enc code to a registered one-hot vector and checks index order.
// Latency 1 clk from a step edge to unenc/locked/err/wrap; no backpressure, step gates sampling.
module seq_decode #(
  parameter int LOCK_COUNT = 4,  // 2..255
  parameter int MISS_LIMIT = 2,  // 1..255
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       enc,
  input  logic             step,
  output logic [7:0]       unenc,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [2:0]       exp_idx;
  logic [2:0]       exp_nxt;
  logic [7:0]       good;
  logic [7:0]       good_nxt;
  logic [7:0]       miss;
  logic [7:0]       miss_nxt;
  logic [7:0]       unenc_nxt;
  logic             locked_nxt;
  logic             err_nxt;
  logic             wrap_nxt;
  logic [ERR_W-1:0] err_cnt_nxt;

  logic             active;
  logic             match;
  logic [2:0]       idx;
  logic [8:0]       good_inc;
  logic [8:0]       miss_inc;

  always_comb begin
    active   = step & enc[3];
    idx      = enc[2:0];
    match    = (idx == exp_idx);
    good_inc = {1'b0, good} + 9'd1;
    miss_inc = {1'b0, miss} + 9'd1;
  end

  // Decode path: idle codes clear the vector, step=0 holds it.
  always_comb begin
    unenc_nxt = unenc;
    if (step) begin
      unenc_nxt = enc[3] ? (8'h01 << idx) : 8'h00;
    end
  end

  always_comb begin
    state_nxt   = state;
    exp_nxt     = exp_idx;
    good_nxt    = good;
    miss_nxt    = miss;
    locked_nxt  = locked;
    err_nxt     = 1'b0;
    wrap_nxt    = 1'b0;
    err_cnt_nxt = err_cnt;

    if (active) begin
      case (state)
        HUNT: begin
          exp_nxt   = idx + 3'd1;
          good_nxt  = 8'd1;
          state_nxt = CHECK;
        end
        CHECK: begin
          if (match) begin
            exp_nxt  = exp_idx + 3'd1;
            good_nxt = good_inc[7:0];
            if (good_inc == 9'(LOCK_COUNT)) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
              miss_nxt   = 8'd0;
            end
          end else begin
            // Resynchronise on the new index without flagging an error.
            exp_nxt  = idx + 3'd1;
            good_nxt = 8'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_nxt  = exp_idx + 3'd1;
            miss_nxt = 8'd0;
            wrap_nxt = (idx == 3'd7);
          end else begin
            err_nxt = 1'b1;
            exp_nxt = idx + 3'd1;
            if (err_cnt != {ERR_W{1'b1}}) begin
              err_cnt_nxt = err_cnt + ERR_W'(1);
            end
            if (miss_inc == 9'(MISS_LIMIT)) begin
              state_nxt  = HUNT;
              locked_nxt = 1'b0;
              miss_nxt   = 8'd0;
            end else begin
              miss_nxt = miss_inc[7:0];
            end
          end
        end
        default: begin
          state_nxt  = HUNT;
          locked_nxt = 1'b0;
          miss_nxt   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      exp_idx <= 3'd0;
      good    <= 8'd0;
      miss    <= 8'd0;
      unenc   <= 8'h00;
      locked  <= 1'b0;
      err     <= 1'b0;
      wrap    <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      exp_idx <= exp_nxt;
      good    <= good_nxt;
      miss    <= miss_nxt;
      unenc   <= unenc_nxt;
      locked  <= locked_nxt;
      err     <= err_nxt;
      wrap    <= wrap_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_seq_decode.sv
// Drives two seq_decode instances (default and ERR_W=2/MISS_LIMIT=255) against a run-length reference model.
module tb_seq_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] enc = 4'h0;
  logic       step = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] u0_unenc, u1_unenc;
  logic       u0_locked, u1_locked, u0_err, u1_err, u0_wrap, u1_wrap;
  logic [7:0] u0_cnt;
  logic [1:0] u1_cnt;

  seq_decode u0 (
    .clk(clk), .rst_n(rst_n), .enc(enc), .step(step),
    .unenc(u0_unenc), .locked(u0_locked), .err(u0_err), .wrap(u0_wrap), .err_cnt(u0_cnt)
  );

  seq_decode #(.LOCK_COUNT(4), .MISS_LIMIT(255), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .enc(enc), .step(step),
    .unenc(u1_unenc), .locked(u1_locked), .err(u1_err), .wrap(u1_wrap), .err_cnt(u1_cnt)
  );

  logic [7:0] unenc_a [2];
  logic       lock_a  [2];
  logic       err_a   [2];
  logic       wrap_a  [2];
  logic [7:0] cnt_a   [2];
  assign unenc_a[0] = u0_unenc;  assign unenc_a[1] = u1_unenc;
  assign lock_a[0]  = u0_locked; assign lock_a[1]  = u1_locked;
  assign err_a[0]   = u0_err;    assign err_a[1]   = u1_err;
  assign wrap_a[0]  = u0_wrap;   assign wrap_a[1]  = u1_wrap;
  assign cnt_a[0]   = u0_cnt;    assign cnt_a[1]   = {6'b0, u1_cnt};

  int checks = 0;
  int failures = 0;

  // Reference model: a lock is a run of LOCK_COUNT consecutive +1 (mod 8) indices;
  // once locked, MISS_LIMIT consecutive out-of-order indices lose it.
  int         p_lock [2] = '{4, 4};
  int         p_miss [2] = '{2, 255};
  int         p_cmax [2] = '{255, 3};
  bit         m_have [2];
  logic [2:0] m_last [2];
  int         m_run  [2];
  bit         m_lk   [2];
  int         m_miss [2];
  int         m_cnt  [2];
  bit         m_err  [2];
  bit         m_wrap [2];
  logic [7:0] m_unenc;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_have[i] = 0; m_last[i] = 3'd0; m_run[i] = 0; m_lk[i] = 0;
      m_miss[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
    end
    m_unenc = 8'h00;
  endtask

  task automatic model_edge(input logic [3:0] e, input logic s);
    int  idx;
    bit  in_order;
    idx = int'(e[2:0]);
    if (s) m_unenc = e[3] ? (8'h01 << idx) : 8'h00;
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      m_wrap[i] = 0;
      if (s && e[3]) begin
        in_order = m_have[i] && (((idx - int'(m_last[i]) + 8) % 8) == 1);
        m_have[i] = 1;
        m_last[i] = e[2:0];
        if (!m_lk[i]) begin
          m_run[i] = in_order ? m_run[i] + 1 : 1;
          if (m_run[i] == p_lock[i]) begin
            m_lk[i] = 1;
            m_miss[i] = 0;
          end
        end else if (in_order) begin
          m_miss[i] = 0;
          m_wrap[i] = (idx == 7);
        end else begin
          m_err[i] = 1;
          if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
          m_miss[i]++;
          if (m_miss[i] == p_miss[i]) begin
            m_lk[i] = 0; m_miss[i] = 0; m_have[i] = 0; m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] e, input logic s);
    @(negedge clk);
    enc = e;
    step = s;
    @(posedge clk);
    model_edge(e, s);
    #1;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (unenc_a[i] !== 8'h00 || lock_a[i] !== 1'b0 || err_a[i] !== 1'b0 ||
          wrap_a[i] !== 1'b0 || cnt_a[i] !== 8'h00) begin
        failures++;
        $display("FAIL reset u%0d: got unenc=%h locked=%b err=%b wrap=%b cnt=%0d, expected all zero",
                 i, unenc_a[i], lock_a[i], err_a[i], wrap_a[i], cnt_a[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [7:0] one;
    for (int k = 0; k < 9; k++) begin
      drive({1'b1, 3'(k)}, 1'b1);
      one = 8'h01 << (k % 8);
      checks++;
      if (u0_unenc !== one || u0_locked !== (k >= 3) || u0_wrap !== (k == 7) || u0_err !== 1'b0) begin
        failures++;
        $display("FAIL sequence step %0d: got unenc=%h locked=%b wrap=%b err=%b, expected unenc=%h locked=%b wrap=%b err=0",
                 k, u0_unenc, u0_locked, u0_wrap, u0_err, one, (k >= 3), (k == 7));
      end
      checks++;
      if (u1_unenc !== m_unenc || u1_locked !== m_lk[1] || u1_wrap !== m_wrap[1]) begin
        failures++;
        $display("FAIL sequence_u1 step %0d: got unenc=%h locked=%b wrap=%b, expected %h %b %b",
                 k, u1_unenc, u1_locked, u1_wrap, m_unenc, m_lk[1], m_wrap[1]);
      end
    end
  endtask

  task automatic test_errors();
    logic [2:0] ids [7] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0, 3'd3};
    bit   e_err  [7] = '{0, 0, 0, 1, 0, 1, 1};
    int   e_cnt  [7] = '{0, 0, 0, 1, 1, 2, 3};
    bit   e_lk   [7] = '{1, 1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      drive({1'b1, ids[k]}, 1'b1);
      checks++;
      if (u0_err !== e_err[k] || u0_cnt !== 8'(e_cnt[k]) || u0_locked !== e_lk[k]) begin
        failures++;
        $display("FAIL errors step %0d: got err=%b cnt=%0d locked=%b, expected err=%b cnt=%0d locked=%b",
                 k, u0_err, u0_cnt, u0_locked, e_err[k], e_cnt[k], e_lk[k]);
      end
      checks++;
      if (u1_err !== m_err[1] || {6'b0, u1_cnt} !== 8'(m_cnt[1]) || u1_locked !== m_lk[1]) begin
        failures++;
        $display("FAIL errors_u1 step %0d: got err=%b cnt=%0d locked=%b, expected %b %0d %b",
                 k, u1_err, u1_cnt, u1_locked, m_err[1], m_cnt[1], m_lk[1]);
      end
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) drive({1'b1, 3'(k)}, 1'b1);
    checks++;
    if (u0_locked !== 1'b1 || u1_locked !== 1'b1) begin
      failures++;
      $display("FAIL idle_relock: got locked u0=%b u1=%b, expected 1 1", u0_locked, u1_locked);
    end
    for (int k = 0; k < 4; k++) begin
      drive((k == 3) ? 4'hA : 4'h0, 1'b1);
      checks++;
      if (u0_unenc !== ((k == 3) ? 8'h04 : 8'h00) || u0_err !== 1'b0 || u0_locked !== 1'b1 ||
          u0_wrap !== 1'b0) begin
        failures++;
        $display("FAIL idle step %0d: got unenc=%h err=%b locked=%b wrap=%b, expected unenc=%h err=0 locked=1 wrap=0",
                 k, u0_unenc, u0_err, u0_locked, u0_wrap, (k == 3) ? 8'h04 : 8'h00);
      end
    end
  endtask

  task automatic test_saturate();
    int e_cnt [6] = '{1, 2, 3, 3, 3, 3};
    sync_reset();
    for (int k = 0; k < 4; k++) drive({1'b1, 3'(k)}, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(4'hD, 1'b1);
      checks++;
      if (u1_cnt !== 2'(e_cnt[k]) || u1_err !== 1'b1 || u1_locked !== 1'b1) begin
        failures++;
        $display("FAIL saturate step %0d: got cnt=%0d err=%b locked=%b, expected cnt=%0d err=1 locked=1",
                 k, u1_cnt, u1_err, u1_locked, e_cnt[k]);
      end
      checks++;
      if (u0_cnt !== 8'(m_cnt[0]) || u0_err !== m_err[0] || u0_locked !== m_lk[0]) begin
        failures++;
        $display("FAIL saturate_u0 step %0d: got cnt=%0d err=%b locked=%b, expected %0d %b %b",
                 k, u0_cnt, u0_err, u0_locked, m_cnt[0], m_err[0], m_lk[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    for (int k = 0; k < 6; k++) drive({1'b1, r + 3'(k)}, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (unenc_a[i] !== 8'h00 || lock_a[i] !== 1'b0 || cnt_a[i] !== 8'h00) begin
        failures++;
        $display("FAIL reset_mid u%0d: got unenc=%h locked=%b cnt=%0d, expected 00 0 0",
                 i, unenc_a[i], lock_a[i], cnt_a[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    r = 3'($urandom_range(0, 7));
    for (int k = 0; k < 4; k++) begin
      drive({1'b1, r + 3'(k)}, 1'b1);
      checks++;
      if (u0_locked !== (k == 3) || u1_locked !== (k == 3)) begin
        failures++;
        $display("FAIL relock step %0d: got locked u0=%b u1=%b, expected %b", k, u0_locked, u1_locked, (k == 3));
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] h_unenc;
    bit         h_lk [2];
    int         h_cnt [2];
    drive({1'b1, m_last[0]}, 1'b1);
    h_unenc = m_unenc;
    for (int i = 0; i < 2; i++) begin h_lk[i] = m_lk[i]; h_cnt[i] = m_cnt[i]; end
    for (int k = 0; k < 5; k++) begin
      drive(4'($urandom), 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (unenc_a[i] !== h_unenc || lock_a[i] !== h_lk[i] || cnt_a[i] !== 8'(h_cnt[i]) ||
            err_a[i] !== 1'b0 || wrap_a[i] !== 1'b0) begin
          failures++;
          $display("FAIL hold u%0d cycle %0d: got unenc=%h locked=%b cnt=%0d err=%b wrap=%b, expected %h %b %0d 0 0",
                   i, k, unenc_a[i], lock_a[i], cnt_a[i], err_a[i], wrap_a[i], h_unenc, h_lk[i], h_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] e;
    int         sel;
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 65)      e = {1'b1, m_last[0] + 3'd1};
      else if (sel < 80) e = {1'b0, 3'($urandom)};
      else               e = 4'($urandom);
      drive(e, ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (unenc_a[i] !== m_unenc || lock_a[i] !== m_lk[i] || err_a[i] !== m_err[i] ||
            wrap_a[i] !== m_wrap[i] || cnt_a[i] !== 8'(m_cnt[i])) begin
          failures++;
          $display("FAIL random u%0d cycle %0d: got unenc=%h locked=%b err=%b wrap=%b cnt=%0d, expected %h %b %b %b %0d",
                   i, k, unenc_a[i], lock_a[i], err_a[i], wrap_a[i], cnt_a[i],
                   m_unenc, m_lk[i], m_err[i], m_wrap[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_errors();
    test_idle();
    test_saturate();
    test_reset_mid();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
